// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock synchronous FIFO with configurable width and depth.
// Provides an occupancy count, almost-full/almost-empty thresholds, a registered
// read port with a valid strobe, and overflow/underflow error pulses.
// Every output is registered.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   wr, wr_data  write request and the data sampled with it
//   rd           read request
//   rd_data      registered read data; holds its value when rd_valid is low
//   rd_valid     rd_data carries a word popped on the previous edge
//   full, empty  count == DEPTH, count == 0
//   almost_full  count >= AF_THRESH
//   almost_empty count <= AE_THRESH
//   count        current occupancy, 0..DEPTH
//   overflow     one-cycle pulse: a write was rejected because the FIFO was full
//   underflow    one-cycle pulse: a read was rejected because the FIFO was empty
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 14,
    parameter int unsigned AE_THRESH = 2,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, empty_q, almost_full_q, almost_empty_q;
    logic              full_d, empty_d, almost_full_d, almost_empty_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q, overflow_q, underflow_q;
    logic              wr_acc, rd_acc;

    // Acceptance uses the registered flags, so a simultaneous write and read on an
    // empty FIFO never falls through, and a write on a full FIFO is always refused.
    always_comb begin
        wr_acc = wr & ~full_q;
        rd_acc = rd & ~empty_q;

        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Flags are computed from the next count so that they change on the same edge
        // as count instead of one cycle later.
        full_d         = (count_d == CW'(DEPTH));
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= CW'(AF_THRESH));
        almost_empty_d = (count_d <= CW'(AE_THRESH));
    end

    // The storage array is not reset; it holds stale data until it is overwritten.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_data_q <= mem[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + AW'(1);
            end
            rd_valid_q     <= rd_acc;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= wr & full_q;
            underflow_q    <= rd & empty_q;
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param (DATA_W=8, DEPTH=16, AF=14, AE=2). A queue-based
// reference model predicts every output after each clock edge.
module tb_sync_fifo_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = 14;
    localparam int AE     = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, full, empty, almost_full, almost_empty;
    logic [4:0]        count;
    logic              overflow, underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_rd_data = '0;
    logic       m_rd_valid = 1'b0;
    logic       m_ov = 1'b0;
    logic       m_un = 1'b0;

    sync_fifo_param #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .wr_data      (wr_data),
        .rd           (rd),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Order: rd_valid, rd_data, full, empty, almost_full, almost_empty, count, ov, un
    function automatic logic [19:0] dut_vec();
        return {rd_valid, rd_data, full, empty, almost_full, almost_empty, count,
                overflow, underflow};
    endfunction

    function automatic logic [19:0] mdl_vec();
        int n;
        n = q.size();
        return {m_rd_valid, m_rd_data, 1'(n == DEPTH), 1'(n == 0), 1'(n >= AF),
                1'(n <= AE), 5'(n), m_ov, m_un};
    endfunction

    // Drive one cycle of stimulus, advance the model across the edge, settle.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic rst);
        logic was_full, was_empty;
        wr = w; wr_data = d; rd = r; reset = rst;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_rd_valid = 1'b0; m_rd_data = '0; m_ov = 1'b0; m_un = 1'b0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            m_ov       = w & was_full;
            m_un       = r & was_empty;
            m_rd_valid = r & ~was_empty;
            if (m_rd_valid) m_rd_data = q.pop_front();
            if (w && !was_full) q.push_back(d);
        end
        #1;
        wr = 1'b0; rd = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_tests++;
        if (dut_vec() !== 20'h0_0000 + {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(),
                     {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 2'b00});
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            n_tests++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL fill_%0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
        n_tests++;
        if ({full, almost_full, count} !== {1'b1, 1'b1, 5'd16}) begin
            n_fail++;
            $display("FAIL full_after_16: got %b expected %b", {full, almost_full, count},
                     {1'b1, 1'b1, 5'd16});
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_tests++;
            if (dut_vec() !== mdl_vec() || rd_data !== 8'(i) || rd_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_%0d: got %h expected %h (data %h want %h)", i,
                         dut_vec(), mdl_vec(), rd_data, 8'(i));
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_tests++;
        if ({empty, rd_valid, count} !== {1'b1, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL empty_after_drain: got %b expected %b", {empty, rd_valid, count},
                     {1'b1, 1'b0, 5'd0});
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom_range(0, 8'h9F)), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        n_tests++;
        if ({overflow, count} !== {1'b1, 5'd16} || dut_vec() !== mdl_vec()) begin
            n_fail++;
            $display("FAIL overflow_pulse: got %h expected %h", dut_vec(), mdl_vec());
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_one_cycle: got %b expected 0", overflow);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_tests++;
            if (dut_vec() !== mdl_vec() || rd_data === 8'hAA) begin
                n_fail++;
                $display("FAIL overflow_drain_%0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_full_wr_rd();
        logic [7:0] oldest;
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        oldest = q[0];
        step(1'b1, 8'h55, 1'b1, 1'b0);
        n_tests++;
        if ({rd_valid, rd_data, overflow, count} !== {1'b1, oldest, 1'b1, 5'd15}) begin
            n_fail++;
            $display("FAIL full_wr_rd: got %h expected %h", {rd_valid, rd_data, overflow, count},
                     {1'b1, oldest, 1'b1, 5'd15});
        end
        step(1'b1, 8'h56, 1'b1, 1'b0);
        n_tests++;
        if (dut_vec() !== mdl_vec() || count !== 5'd15) begin
            n_fail++;
            $display("FAIL both_accepted: got %h expected %h", dut_vec(), mdl_vec());
        end
        while (q.size() > 0) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_tests++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL full_wr_rd_drain: got %h expected %h", dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_empty_wr_rd();
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        n_tests++;
        if ({underflow, rd_valid, count, empty} !== {1'b1, 1'b0, 5'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL empty_wr_rd: got %b expected %b", {underflow, rd_valid, count, empty},
                     {1'b1, 1'b0, 5'd1, 1'b0});
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if ({rd_valid, rd_data, underflow, count} !== {1'b1, 8'h3C, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL empty_wr_rd_read: got %h expected %h",
                     {rd_valid, rd_data, underflow, count}, {1'b1, 8'h3C, 1'b0, 5'd0});
        end
    endtask

    task automatic test_wrap_and_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            n_tests++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL wrap_%0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
        step(1'b1, 8'h11, 1'b1, 1'b1);
        n_tests++;
        if ({count, empty, full, rd_valid} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: got %b expected %b", {count, empty, full, rd_valid},
                     {5'd0, 1'b1, 1'b0, 1'b0});
        end
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_tests++;
        if ({rd_valid, rd_data, count} !== {1'b1, 8'h77, 5'd0}) begin
            n_fail++;
            $display("FAIL after_reset_77: got %h expected %h", {rd_valid, rd_data, count},
                     {1'b1, 8'h77, 5'd0});
        end
    endtask

    task automatic test_random();
        int bias;
        for (int i = 0; i < 400; i++) begin
            bias = (i / 100) % 2 == 0 ? 75 : 25;  // alternate fill-heavy / drain-heavy
            step(1'($urandom_range(0, 99) < bias), 8'($urandom),
                 1'($urandom_range(0, 99) >= bias), 1'($urandom_range(0, 199) == 0));
            n_tests++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL random_%0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_wr_rd();
        test_empty_wr_rd();
        test_wrap_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
